// File: rtl/nor_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nor_ctrl_pkg                                               |
// | Description : Shared types and constants for the NOR flash cycle        |
// |               controller: the controller state enum, the bus widths and  |
// |               the default timing values.                                 |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package nor_ctrl_pkg;

   localparam int unsigned c_addr_w         = 26;
   localparam int unsigned c_data_w         = 16;
   localparam int unsigned c_cnt_w          = 24;

   localparam int unsigned c_t_setup_def    = 2;
   localparam int unsigned c_t_strobe_def   = 6;
   localparam int unsigned c_t_hold_def     = 2;
   localparam int unsigned c_t_blank_def    = 4;
   localparam int unsigned c_ry_timeout_def = 1048576;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_STROBE  = 3'd2,
      S_HOLD    = 3'd3,
      S_BLANK   = 3'd4,
      S_WAIT_RY = 3'd5,
      S_DONE    = 3'd6
   } state_e;

endpackage
`default_nettype wire

// File: rtl/nor_ry_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nor_ry_sync                                                |
// | Description : Two-flop synchronizer for the asynchronous RY/BY# pin.     |
// | Ports       : clk_i   - system clock                                     |
// |               reset_i - synchronous active-high reset                    |
// |               async_i - asynchronous input                               |
// |               sync_o  - synchronized output (two clocks of latency)      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module nor_ry_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/nor_cycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nor_cycle_ctrl                                             |
// | Description : Sequences one asynchronous NOR flash read or write cycle   |
// |               per accepted request (setup / strobe / hold), optionally   |
// |               followed by a blanking period and a bounded RY/BY# wait.   |
// | Ports       : clk_i, reset_i          - clock, sync active-high reset    |
// |               req_*                   - valid/ready request channel      |
// |               rsp_*                   - one-cycle completion response    |
// |               nor_*                   - registered flash pins (CE/OE/WE  |
// |                                         active-low), RY async input      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module nor_cycle_ctrl
   import nor_ctrl_pkg::*;
#(
   parameter int unsigned T_SETUP    = c_t_setup_def,
   parameter int unsigned T_STROBE   = c_t_strobe_def,
   parameter int unsigned T_HOLD     = c_t_hold_def,
   parameter int unsigned T_BLANK    = c_t_blank_def,
   parameter int unsigned RY_TIMEOUT = c_ry_timeout_def
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic                req_wait_ry_i,
   input  logic [c_addr_w-1:0] req_addr_i,
   input  logic [c_data_w-1:0] req_wdata_i,
   output logic                rsp_valid_o,
   output logic [c_data_w-1:0] rsp_rdata_o,
   output logic                rsp_timeout_o,
   output logic [c_addr_w-1:0] nor_addr_o,
   output logic [c_data_w-1:0] nor_data_o,
   output logic                nor_data_oe,
   input  logic [c_data_w-1:0] nor_data_i,
   output logic                nor_ce_o,
   output logic                nor_oe_o,
   output logic                nor_we_o,
   input  logic                nor_ry_i
);

   // The shared counter is loaded with (duration - 1) on state entry and the
   // state is left on the cycle it reads zero.
   localparam logic [c_cnt_w-1:0] c_ld_setup   = c_cnt_w'(T_SETUP - 1);
   localparam logic [c_cnt_w-1:0] c_ld_strobe  = c_cnt_w'(T_STROBE - 1);
   localparam logic [c_cnt_w-1:0] c_ld_hold    = c_cnt_w'(T_HOLD - 1);
   localparam logic [c_cnt_w-1:0] c_ld_blank   = c_cnt_w'(T_BLANK - 1);
   localparam logic [c_cnt_w-1:0] c_ld_timeout = c_cnt_w'(RY_TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

   state_e                state_q, state_d;
   logic [c_cnt_w-1:0]    cnt_q, cnt_d;
   logic                  req_we_q, req_we_d;
   logic                  wait_ry_q, wait_ry_d;
   logic [c_addr_w-1:0]   addr_q, addr_d;
   logic [c_data_w-1:0]   wdata_q, wdata_d;
   logic [c_data_w-1:0]   rdata_q, rdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  ce_n_q, ce_n_d;
   logic                  oe_n_q, oe_n_d;
   logic                  we_n_q, we_n_d;
   logic                  data_oe_q, data_oe_d;
   logic                  ry_synced;
   logic                  cnt_zero;
   logic                  bus_cycle;

   nor_ry_sync u_ry_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .async_i (nor_ry_i),
      .sync_o  (ry_synced)
   );

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      req_we_d      = req_we_q;
      wait_ry_d     = wait_ry_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      rsp_timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               state_d   = S_SETUP;
               cnt_d     = c_ld_setup;
               req_we_d  = req_we_i;
               wait_ry_d = req_wait_ry_i;
               addr_d    = req_addr_i;
               wdata_d   = req_wdata_i;
            end
         end
         S_SETUP: begin
            if (cnt_zero) begin
               state_d = S_STROBE;
               cnt_d   = c_ld_strobe;
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         S_STROBE: begin
            if (cnt_zero) begin
               state_d = S_HOLD;
               cnt_d   = c_ld_hold;
               // Sample read data while OE is still low (last strobe cycle).
               if (!req_we_q) begin
                  rdata_d = nor_data_i;
               end
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         S_HOLD: begin
            if (cnt_zero) begin
               if (wait_ry_q) begin
                  state_d = S_BLANK;
                  cnt_d   = c_ld_blank;
               end else begin
                  state_d = S_DONE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         S_BLANK: begin
            // RY is not trusted yet: the device needs time to assert busy.
            if (cnt_zero) begin
               state_d = S_WAIT_RY;
               cnt_d   = c_ld_timeout;
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         S_WAIT_RY: begin
            if (ry_synced) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else if (cnt_zero) begin
               state_d       = S_DONE;
               cnt_d         = '0;
               rsp_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Pin values are derived from the next state so the flops present
      // them in the same cycle the state register enters that state.
      bus_cycle   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      ce_n_d      = !bus_cycle;
      oe_n_d      = !((state_d == S_STROBE) && !req_we_d);
      we_n_d      = !((state_d == S_STROBE) && req_we_d);
      data_oe_d   = bus_cycle && req_we_d;
      rsp_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         req_we_q      <= 1'b0;
         wait_ry_q     <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         ce_n_q        <= 1'b1;
         oe_n_q        <= 1'b1;
         we_n_q        <= 1'b1;
         data_oe_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         req_we_q      <= req_we_d;
         wait_ry_q     <= wait_ry_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_timeout_q <= rsp_timeout_d;
         ce_n_q        <= ce_n_d;
         oe_n_q        <= oe_n_d;
         we_n_q        <= we_n_d;
         data_oe_q     <= data_oe_d;
      end
   end

   assign req_ready_o   = (state_q == S_IDLE) && !reset_i;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rdata_q;
   assign rsp_timeout_o = rsp_timeout_q;
   assign nor_addr_o    = addr_q;
   assign nor_data_o    = wdata_q;
   assign nor_data_oe   = data_oe_q;
   assign nor_ce_o      = ce_n_q;
   assign nor_oe_o      = oe_n_q;
   assign nor_we_o      = we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_nor_cycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_nor_cycle_ctrl                                          |
// | Description : Self-checking bench for nor_cycle_ctrl. Expected pin and   |
// |               response timing is computed per cycle offset from the     |
// |               accept cycle using the timing parameters.                  |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_nor_cycle_ctrl;

   localparam int T_S = 2;
   localparam int T_T = 6;
   localparam int T_H = 2;
   localparam int T_B = 4;
   localparam int TO2 = 16;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        req_valid_i, req_valid2_i;
   logic        req_we_i, req_wait_ry_i;
   logic [25:0] req_addr_i;
   logic [15:0] req_wdata_i;
   logic [15:0] nor_data_i;
   logic        nor_ry_i;

   logic        req_ready_o, rsp_valid_o, rsp_timeout_o;
   logic [15:0] rsp_rdata_o, nor_data_o;
   logic [25:0] nor_addr_o;
   logic        nor_data_oe, nor_ce_o, nor_oe_o, nor_we_o;

   logic        ready2, rsp_valid2, timeout2, data_oe2, ce2, oe2, we2;
   logic [15:0] rdata2, data2;
   logic [25:0] addr2;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   logic [15:0] rd_model;

   always #5 clk = ~clk;

   nor_cycle_ctrl u_dut (
      .clk_i(clk), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_wait_ry_i(req_wait_ry_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_timeout_o(rsp_timeout_o),
      .nor_addr_o(nor_addr_o), .nor_data_o(nor_data_o), .nor_data_oe(nor_data_oe),
      .nor_data_i(nor_data_i), .nor_ce_o(nor_ce_o), .nor_oe_o(nor_oe_o),
      .nor_we_o(nor_we_o), .nor_ry_i(nor_ry_i)
   );

   nor_cycle_ctrl #(.RY_TIMEOUT(TO2)) u_dut_to (
      .clk_i(clk), .reset_i(reset_i),
      .req_valid_i(req_valid2_i), .req_ready_o(ready2),
      .req_we_i(req_we_i), .req_wait_ry_i(req_wait_ry_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid2), .rsp_rdata_o(rdata2), .rsp_timeout_o(timeout2),
      .nor_addr_o(addr2), .nor_data_o(data2), .nor_data_oe(data_oe2),
      .nor_data_i(nor_data_i), .nor_ce_o(ce2), .nor_oe_o(oe2),
      .nor_we_o(we2), .nor_ry_i(nor_ry_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete request on the default-timing DUT. ry_rel is the offset
   // (from the accept cycle) at which RY goes high.
   task automatic run_txn(input logic we, input logic wr, input logic [25:0] a,
                          input logic [15:0] wd, input int ry_rel);
      int su, w, c, done_k;
      logic [15:0] exp_rd;
      su     = T_S + T_T + T_H;
      exp_rd = rd_model;
      if (!wr) begin
         done_k = su + 1;
      end else begin
         w      = su + T_B + 1;                    // first WAIT_RY cycle
         c      = (ry_rel + 2 > w) ? ry_rel + 2 : w; // first cycle synced RY seen
         done_k = c + 1;
      end
      req_valid_i   = 1'b1;
      req_we_i      = we;
      req_wait_ry_i = wr;
      req_addr_i    = a;
      req_wdata_i   = wd;
      for (int k = 0; k <= done_k; k++) begin
         nor_data_i = 16'($urandom);
         if (k == T_S + T_T && !we) exp_rd = nor_data_i;
         nor_ry_i = (k >= ry_rel);
         @(negedge clk);
         chk("ready",     32'(req_ready_o),   32'(k == 0));
         chk("ce_n",      32'(nor_ce_o),      32'(!(k >= 1 && k <= su)));
         chk("oe_n",      32'(nor_oe_o),      32'(!(!we && k >= T_S + 1 && k <= T_S + T_T)));
         chk("we_n",      32'(nor_we_o),      32'(!(we && k >= T_S + 1 && k <= T_S + T_T)));
         chk("data_oe",   32'(nor_data_oe),   32'(we && k >= 1 && k <= su));
         chk("rsp_valid", 32'(rsp_valid_o),   32'(k == done_k));
         chk("timeout",   32'(rsp_timeout_o), 32'(0));
         if (k >= 1 && k <= su) begin
            chk("addr", 32'(nor_addr_o), 32'(a));
            if (we) chk("wdata", 32'(nor_data_o), 32'(wd));
         end
         if (k == done_k && !we) chk("rdata", 32'(rsp_rdata_o), 32'(exp_rd));
         @(posedge clk); #1;
         if (k == 0) req_valid_i = 1'b0;
      end
      if (!we) rd_model = exp_rd;
   endtask

   initial begin
      logic [25:0] addrs [3];
      logic [15:0] exp_b2b;
      int          done_to;

      reset_i       = 1'b1;
      req_valid_i   = 1'b0;
      req_valid2_i  = 1'b0;
      req_we_i      = 1'b0;
      req_wait_ry_i = 1'b0;
      req_addr_i    = '0;
      req_wdata_i   = '0;
      nor_data_i    = '0;
      nor_ry_i      = 1'b1;
      rd_model      = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("ready_in_reset", 32'(req_ready_o), 32'(0));
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("rst_ready",   32'(req_ready_o),   32'(1));
      chk("rst_ce",      32'(nor_ce_o),      32'(1));
      chk("rst_oe",      32'(nor_oe_o),      32'(1));
      chk("rst_we",      32'(nor_we_o),      32'(1));
      chk("rst_data_oe", 32'(nor_data_oe),   32'(0));
      chk("rst_addr",    32'(nor_addr_o),    32'(0));
      chk("rst_data_o",  32'(nor_data_o),    32'(0));
      chk("rst_valid",   32'(rsp_valid_o),   32'(0));
      chk("rst_timeout", 32'(rsp_timeout_o), 32'(0));
      chk("rst_rdata",   32'(rsp_rdata_o),   32'(0));
      @(posedge clk); #1;

      // Directed read, write, write with RY wait released at offset 30
      run_txn(1'b0, 1'b0, 26'h0012345, 16'h0000, 0);
      run_txn(1'b1, 1'b0, 26'h0000555, 16'h00AA, 0);
      run_txn(1'b1, 1'b1, 26'h0000AAA, 16'h0055, 30);

      // Randomized mix
      for (int i = 0; i < 10; i++) begin
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 26'($urandom),
                 16'($urandom), int'($urandom_range(0, 40)));
      end

      // Back-to-back reads with valid held high
      for (int i = 0; i < 3; i++) addrs[i] = 26'($urandom);
      exp_b2b       = '0;
      req_we_i      = 1'b0;
      req_wait_ry_i = 1'b0;
      req_addr_i    = addrs[0];
      req_valid_i   = 1'b1;
      for (int k = 0; k < 36; k++) begin
         nor_data_i = 16'($urandom);
         if (k % 12 == 8) exp_b2b = nor_data_i;
         @(negedge clk);
         chk("b2b_ready", 32'(req_ready_o), 32'(k % 12 == 0));
         chk("b2b_valid", 32'(rsp_valid_o), 32'(k % 12 == 11));
         if (k % 12 == 1) chk("b2b_addr", 32'(nor_addr_o), 32'(addrs[k / 12]));
         if (k % 12 == 11) chk("b2b_rdata", 32'(rsp_rdata_o), 32'(exp_b2b));
         @(posedge clk); #1;
         if (k == 0)  req_addr_i = addrs[1];
         if (k == 12) req_addr_i = addrs[2];
         if (k == 24) req_valid_i = 1'b0;
      end
      rd_model = exp_b2b;

      // Reset pulsed during STROBE of a read
      req_we_i    = 1'b0;
      req_addr_i  = 26'h3FFFFFF;
      req_valid_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) chk("ab_ready", 32'(req_ready_o), 32'(1));
         @(posedge clk); #1;
         if (k == 0) req_valid_i = 1'b0;
      end
      reset_i = 1'b1;
      @(negedge clk);
      chk("ab_oe_strobe", 32'(nor_oe_o),    32'(0));
      chk("ab_ready_rst", 32'(req_ready_o), 32'(0));
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("ab_ce",      32'(nor_ce_o),    32'(1));
      chk("ab_oe",      32'(nor_oe_o),    32'(1));
      chk("ab_we",      32'(nor_we_o),    32'(1));
      chk("ab_data_oe", 32'(nor_data_oe), 32'(0));
      chk("ab_ready",   32'(req_ready_o), 32'(1));
      chk("ab_rdata",   32'(rsp_rdata_o), 32'(0));
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("ab_no_valid", 32'(rsp_valid_o), 32'(0));
      end
      @(posedge clk); #1;
      rd_model = '0;

      // RY stuck busy on the short-timeout instance
      done_to       = T_S + T_T + T_H + T_B + 1 + TO2;
      nor_ry_i      = 1'b0;
      req_we_i      = 1'b1;
      req_wait_ry_i = 1'b1;
      req_addr_i    = 26'h0001234;
      req_wdata_i   = 16'h3030;
      req_valid2_i  = 1'b1;
      for (int k = 0; k <= done_to; k++) begin
         @(negedge clk);
         chk("to_ready",   32'(ready2),     32'(k == 0));
         chk("to_valid",   32'(rsp_valid2), 32'(k == done_to));
         chk("to_timeout", 32'(timeout2),   32'(k == done_to));
         @(posedge clk); #1;
         if (k == 0) req_valid2_i = 1'b0;
      end
      @(negedge clk);
      chk("to_idle_ready", 32'(ready2),   32'(1));
      chk("to_clear",      32'(timeout2), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
